// File: rtl/radix3_bfly_pipe_pkg.sv
// rtl/radix3_bfly_pipe_pkg.sv - shared FFT constants for the radix-3 butterfly
// Purpose: default fractional width, radix-3 pipeline latency and the sqrt(3)/2
//          constant generator used by the butterfly and its constant multiplier.
// Ports:   none (package).
package radix3_bfly_pipe_pkg;

    localparam int KF_DEFAULT = 16;
    localparam int RADIX3_LAT = 4;

    // Bit-serial integer square root: floor(sqrt(x)) for x < 2^62.
    function automatic longint unsigned isqrt(input longint unsigned x);
        longint unsigned r;
        longint unsigned c;
        r = 64'd0;
        for (int i = 31; i >= 0; i--) begin
            c = r | (64'd1 << i);
            if (c * c <= x) begin
                r = c;
            end
        end
        return r;
    endfunction

    // round(sqrt(3)/2 * 2^kf) without real arithmetic:
    // floor(sqrt(3 * 4^kf)) = floor(2*K_exact), and round(v) = (floor(2v) + 1) >> 1.
    function automatic int unsigned k_sqrt3_2(input int kf);
        longint unsigned two_k;
        two_k = isqrt(64'd3 << (2 * kf));
        return 32'((two_k + 64'd1) >> 1);
    endfunction

    localparam int unsigned K_SQRT3_2 = k_sqrt3_2(KF_DEFAULT);

endpackage

// File: rtl/radix3_bfly_pipe_if.sv
// rtl/radix3_bfly_pipe_if.sv - sample-set stream interface of the radix-3 butterfly
// Purpose: groups the input sample-set (in_valid, inv, a/b/c) and the output
//          sample-set (out_valid, x0/x1/x2) of the butterfly.
// Ports:   master drives in_valid/inv/a/b/c and observes out_valid/x*;
//          slave (the butterfly) is the reverse. Outputs are W+2 bits wide.
interface radix3_bfly_pipe_if #(
    parameter int W = 16
);
    localparam int OW = W + 2;

    logic                in_valid;
    logic                inv;
    logic signed [W-1:0] a_re;
    logic signed [W-1:0] a_img;
    logic signed [W-1:0] b_re;
    logic signed [W-1:0] b_img;
    logic signed [W-1:0] c_re;
    logic signed [W-1:0] c_img;

    logic                 out_valid;
    logic signed [OW-1:0] x0_re;
    logic signed [OW-1:0] x0_img;
    logic signed [OW-1:0] x1_re;
    logic signed [OW-1:0] x1_img;
    logic signed [OW-1:0] x2_re;
    logic signed [OW-1:0] x2_img;

    modport master (
        output in_valid, inv, a_re, a_img, b_re, b_img, c_re, c_img,
        input  out_valid, x0_re, x0_img, x1_re, x1_img, x2_re, x2_img
    );

    modport slave (
        input  in_valid, inv, a_re, a_img, b_re, b_img, c_re, c_img,
        output out_valid, x0_re, x0_img, x1_re, x1_img, x2_re, x2_img
    );

endinterface

// File: rtl/radix3_bfly_pipe_k_mult.sv
// rtl/radix3_bfly_pipe_k_mult.sv - registered complex-by-real-constant multiply with rounding
// Purpose: t = round_half_up(d * K / 2^KF) per component, two register stages
//          (product, then rounded/truncated result). Reusable by other kernels.
// Ports:   clk, rst (async, active-high);
//          d_re, d_img  in  DW signed operand;
//          t_re, t_img  out DW signed result, valid two cycles after d.
module k_mult #(
    parameter int          DW = 17,
    parameter int          KF = 16,
    parameter int unsigned K  = 56756
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] d_re,
    input  logic signed [DW-1:0] d_img,
    output logic signed [DW-1:0] t_re,
    output logic signed [DW-1:0] t_img
);

    // |d| <= 2^(DW-1) and K < 2^KF keep the product and the rounding add inside PW.
    localparam int PW = DW + KF + 1;
    localparam logic signed [PW-1:0] K_P  = PW'(K);
    localparam logic signed [PW-1:0] HALF = PW'(64'd1 << (KF - 1));

    logic signed [PW-1:0] p_re;
    logic signed [PW-1:0] p_img;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_re  <= '0;
            p_img <= '0;
            t_re  <= '0;
            t_img <= '0;
        end else begin
            p_re  <= PW'(d_re) * K_P;
            p_img <= PW'(d_img) * K_P;
            // Adding half then arithmetic shift = round half toward +inf.
            t_re  <= DW'((p_re + HALF) >>> KF);
            t_img <= DW'((p_img + HALF) >>> KF);
        end
    end

endmodule

// File: rtl/radix3_bfly_pipe.sv
// rtl/radix3_bfly_pipe.sv - fully pipelined fixed-point radix-3 DFT butterfly
// Purpose: X0 = a+b+c, X1/X2 = a + b*W^k + c*W^2k with W = e^-+j2pi/3 chosen per
//          sample-set by inv; fixed latency RADIX3_LAT (4), one set per cycle.
// Ports:   clk, rst (async, active-high);
//          bus (slave): in_valid, inv, a/b/c (W signed) in;
//                       out_valid, x0/x1/x2 (W+2 signed) out.
module radix3_bfly_pipe
    import radix3_bfly_pipe_pkg::*;
#(
    parameter int W  = 16,
    parameter int KF = KF_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    radix3_bfly_pipe_if.slave bus
);

    localparam int          DW = W + 1;
    localparam int          OW = W + 2;
    localparam int unsigned K  = k_sqrt3_2(KF);

    // Stage 1: sum/difference of b and c, a delayed
    logic signed [DW-1:0] s_re, s_img, d_re, d_img;
    logic signed [W-1:0]  a1_re, a1_img;

    // Stage 2: X0 and the real-axis term m = a - s/2
    logic signed [OW-1:0] x0_re2, x0_img2, m_re2, m_img2;

    // Stage 3: delay-matched to the constant multiplier output t
    logic signed [OW-1:0] x0_re3, x0_img3, m_re3, m_img3;
    logic signed [DW-1:0] t_re, t_img;

    // Stage 4: output registers
    logic signed [OW-1:0] x0_re_q, x0_img_q, x1_re_q, x1_img_q, x2_re_q, x2_img_q;

    // valid travels all four stages; inv is consumed by the stage-4 mux,
    // so its last tap is the stage-3 bit.
    logic [RADIX3_LAT-1:0] vld_sr;
    logic [RADIX3_LAT-2:0] inv_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr <= '0;
            inv_sr <= '0;
        end else begin
            vld_sr <= {vld_sr[RADIX3_LAT-2:0], bus.in_valid};
            inv_sr <= {inv_sr[RADIX3_LAT-3:0], bus.inv};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_re   <= '0;
            s_img  <= '0;
            d_re   <= '0;
            d_img  <= '0;
            a1_re  <= '0;
            a1_img <= '0;
        end else begin
            s_re   <= DW'(bus.b_re) + DW'(bus.c_re);
            s_img  <= DW'(bus.b_img) + DW'(bus.c_img);
            d_re   <= DW'(bus.b_re) - DW'(bus.c_re);
            d_img  <= DW'(bus.b_img) - DW'(bus.c_img);
            a1_re  <= bus.a_re;
            a1_img <= bus.a_img;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_re2  <= '0;
            x0_img2 <= '0;
            m_re2   <= '0;
            m_img2  <= '0;
            x0_re3  <= '0;
            x0_img3 <= '0;
            m_re3   <= '0;
            m_img3  <= '0;
        end else begin
            x0_re2  <= OW'(a1_re) + OW'(s_re);
            x0_img2 <= OW'(a1_img) + OW'(s_img);
            // cos(2pi/3) = -1/2; the arithmetic shift floors odd sums.
            m_re2   <= OW'(a1_re) - OW'(s_re >>> 1);
            m_img2  <= OW'(a1_img) - OW'(s_img >>> 1);
            x0_re3  <= x0_re2;
            x0_img3 <= x0_img2;
            m_re3   <= m_re2;
            m_img3  <= m_img2;
        end
    end

    // t = (b - c) * sin(2pi/3), produced at stage 3
    k_mult #(
        .DW (DW),
        .KF (KF),
        .K  (K)
    ) u_k_mult (
        .clk   (clk),
        .rst   (rst),
        .d_re  (d_re),
        .d_img (d_img),
        .t_re  (t_re),
        .t_img (t_img)
    );

    // Forward: X1 = m - j*t, X2 = m + j*t. Inverse swaps the two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_re_q  <= '0;
            x0_img_q <= '0;
            x1_re_q  <= '0;
            x1_img_q <= '0;
            x2_re_q  <= '0;
            x2_img_q <= '0;
        end else begin
            x0_re_q  <= x0_re3;
            x0_img_q <= x0_img3;
            if (inv_sr[RADIX3_LAT-2]) begin
                x1_re_q  <= m_re3 - OW'(t_img);
                x1_img_q <= m_img3 + OW'(t_re);
                x2_re_q  <= m_re3 + OW'(t_img);
                x2_img_q <= m_img3 - OW'(t_re);
            end else begin
                x1_re_q  <= m_re3 + OW'(t_img);
                x1_img_q <= m_img3 - OW'(t_re);
                x2_re_q  <= m_re3 - OW'(t_img);
                x2_img_q <= m_img3 + OW'(t_re);
            end
        end
    end

    assign bus.out_valid = vld_sr[RADIX3_LAT-1];
    assign bus.x0_re     = x0_re_q;
    assign bus.x0_img    = x0_img_q;
    assign bus.x1_re     = x1_re_q;
    assign bus.x1_img    = x1_img_q;
    assign bus.x2_re     = x2_re_q;
    assign bus.x2_img    = x2_img_q;

endmodule

// File: tb/tb_radix3_bfly_pipe.sv
// tb/tb_radix3_bfly_pipe.sv - self-checking bench for radix3_bfly_pipe
module tb_radix3_bfly_pipe;

    localparam int  W  = 16;
    localparam int  NV = 12;
    localparam real H  = 0.8660254037844386;

    typedef struct {
        int ar, ai, br, bi, cr, ci;
        bit inv;
        int x0r, x0i, x1r, x1i, x2r, x2i;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    radix3_bfly_pipe_if #(.W(W)) bus ();

    radix3_bfly_pipe #(.W(W), .KF(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t vt[NV];
    vec_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_near(input string name, input longint act, input real exp);
        real diff;
        n_chk++;
        diff = real'(act) - exp;
        if (diff > 1.2 || diff < -1.2) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0.3f +-1", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input bit vld);
        bus.in_valid = vld;
        bus.inv      = v.inv;
        bus.a_re     = W'(v.ar);
        bus.a_img    = W'(v.ai);
        bus.b_re     = W'(v.br);
        bus.b_img    = W'(v.bi);
        bus.c_re     = W'(v.cr);
        bus.c_img    = W'(v.ci);
    endtask

    task automatic idle();
        vec_t z;
        z = '{0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0};
        drive(z, 1'b0);
    endtask

    task automatic chk_vec(input string tag, input vec_t v);
        chk({tag, "_x0_re"}, bus.x0_re,  v.x0r);
        chk({tag, "_x0_im"}, bus.x0_img, v.x0i);
        chk({tag, "_x1_re"}, bus.x1_re,  v.x1r);
        chk({tag, "_x1_im"}, bus.x1_img, v.x1i);
        chk({tag, "_x2_re"}, bus.x2_re,  v.x2r);
        chk({tag, "_x2_im"}, bus.x2_img, v.x2i);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_x0_re"}, bus.x0_re, 0);
        chk({tag, "_x0_im"}, bus.x0_img, 0);
        chk({tag, "_x1_re"}, bus.x1_re, 0);
        chk({tag, "_x1_im"}, bus.x1_img, 0);
        chk({tag, "_x2_re"}, bus.x2_re, 0);
        chk({tag, "_x2_im"}, bus.x2_img, 0);
    endtask

    // Floating-point DFT-3: W1 = e^(sg*j*2pi/3), sg = -1 forward, +1 inverse.
    task automatic chk_model(input string tag, input vec_t v);
        real sg, w1r, w1i, w2r, w2i;
        real e0r, e0i, e1r, e1i, e2r, e2i;
        sg  = v.inv ? 1.0 : -1.0;
        w1r = -0.5;  w1i = sg * H;
        w2r = -0.5;  w2i = -sg * H;
        e0r = real'(v.ar + v.br + v.cr);
        e0i = real'(v.ai + v.bi + v.ci);
        e1r = v.ar + (v.br * w1r - v.bi * w1i) + (v.cr * w2r - v.ci * w2i);
        e1i = v.ai + (v.br * w1i + v.bi * w1r) + (v.cr * w2i + v.ci * w2r);
        e2r = v.ar + (v.br * w2r - v.bi * w2i) + (v.cr * w1r - v.ci * w1i);
        e2i = v.ai + (v.br * w2i + v.bi * w2r) + (v.cr * w1i + v.ci * w1r);
        chk_near({tag, "_x0_re"}, bus.x0_re,  e0r);
        chk_near({tag, "_x0_im"}, bus.x0_img, e0i);
        chk_near({tag, "_x1_re"}, bus.x1_re,  e1r);
        chk_near({tag, "_x1_im"}, bus.x1_img, e1i);
        chk_near({tag, "_x2_re"}, bus.x2_re,  e2r);
        chk_near({tag, "_x2_im"}, bus.x2_img, e2i);
    endtask

    initial begin
        vec_t r;
        vec_t hv;
        bit   inv_t;
        int   n_in;
        int   n_out;

        //        ar     ai     br     bi     cr     ci   inv   x0r     x0i    x1r    x1i     x2r    x2i
        vt[0]  = '{100,   0,    100,   0,     100,   0,   1'b0, 300,    0,     0,     0,      0,     0};
        vt[1]  = '{1,     0,    0,     0,     0,     0,   1'b0, 1,      0,     1,     0,      1,     0};
        vt[2]  = '{1,     0,    0,     0,     0,     0,   1'b1, 1,      0,     1,     0,      1,     0};
        vt[3]  = '{0,     0,    1000,  0,     0,     0,   1'b0, 1000,   0,     -500,  -866,   -500,  866};
        vt[4]  = '{0,     0,    1000,  0,     0,     0,   1'b1, 1000,   0,     -500,  866,    -500,  -866};
        vt[5]  = '{-32768,-32768,-32768,-32768,-32768,-32768,1'b0,-98304,-98304,0,   0,      0,     0};
        vt[6]  = '{0,     0,    0,     0,     1000,  0,   1'b0, 1000,   0,     -500,  866,    -500,  -866};
        vt[7]  = '{0,     0,    0,     1000,  0,     0,   1'b0, 0,      1000,  866,   -500,   -866,  -500};
        vt[8]  = '{0,     0,    8192,  0,     0,     0,   1'b1, 8192,   0,     -4096, 7095,   -4096, -7095};
        vt[9]  = '{0,     0,    -8192, 0,     0,     0,   1'b0, -8192,  0,     4096,  7094,   4096,  -7094};
        vt[10] = '{0,     0,    -1,    0,     0,     0,   1'b0, -1,     0,     1,     1,      1,     -1};
        vt[11] = '{32767, 32767,32767, 32767, -32768,-32768,1'b0,32766, 32766, 89523, -23987, -23987, 89523};

        rst = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // Directed vectors back-to-back; each result appears 4 cycles after its input.
        for (int i = 0; i < NV + 4; i++) begin
            @(negedge clk);
            if (i >= 4) begin
                chk($sformatf("vec%0d_valid", i - 4), bus.out_valid, 1);
                chk_vec($sformatf("vec%0d", i - 4), vt[i - 4]);
            end else begin
                chk($sformatf("lat_early%0d", i), bus.out_valid, 0);
            end
            if (i < NV) drive(vt[i], 1'b1);
            else        idle();
        end
        @(negedge clk);
        chk("tail_bubble_valid", bus.out_valid, 0);

        // Random stream with ~70% valid, inv toggling per set.
        inv_t = 1'b0;
        n_in  = 0;
        n_out = 0;
        for (int cyc = 0; cyc < 68; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                n_out++;
                if (q.size() == 0) begin
                    chk("rand_unexpected_out", 1, 0);
                end else begin
                    r = q.pop_front();
                    chk_model($sformatf("rand%0d", n_out), r);
                end
            end
            if (cyc < 60 && $urandom_range(99) < 70) begin
                r.ar  = int'($urandom_range(8190)) - 4095;
                r.ai  = int'($urandom_range(8190)) - 4095;
                r.br  = int'($urandom_range(8190)) - 4095;
                r.bi  = int'($urandom_range(8190)) - 4095;
                r.cr  = int'($urandom_range(8190)) - 4095;
                r.ci  = int'($urandom_range(8190)) - 4095;
                r.inv = inv_t;
                inv_t = ~inv_t;
                drive(r, 1'b1);
                q.push_back(r);
                n_in++;
            end else begin
                idle();
            end
        end
        chk("rand_out_count", n_out, n_in);

        // Reset with three sets in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(vt[3 + i], 1'b1);
        end
        @(negedge clk);
        idle();
        rst = 1'b1;
        #1;
        chk_zero("midrst_now");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_flush%0d_valid", i), bus.out_valid, 0);
            chk($sformatf("midrst_flush%0d_x0_re", i), bus.x0_re, 0);
        end

        // First post-reset set must arrive exactly 4 cycles later.
        hv = vt[3];
        drive(hv, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            idle();
            chk($sformatf("postrst_lat%0d_valid", k), bus.out_valid, (k == 4) ? 1 : 0);
        end
        chk_vec("postrst", hv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
